bcd_addsub_seq: RTL
===================

// Module: bcd_addsub_seq
// PURPOSE
//   Multi-digit BCD adder/subtractor, processing one decimal digit per clock from LSD to MSD.
//   Generalises the single-digit BCD adder in four ways: DIGITS-wide operands, add/subtract
//   mode, start/busy/done handshake, and detection of invalid (>9) input digits.
//   Feeds the decimal display/accumulator datapath; results are held stable between operations.
// PARAMETERS
//   DIGITS  4  number of BCD digits per operand (>=1); operand width = 4*DIGITS
// PORTS
//   clk      in   1         rising-edge clock
//   rst      in   1         asynchronous reset, active-high
//   start    in   1         request; sampled only in IDLE
//   mode     in   1         0 = A+B+cin, 1 = A-B-cin (cin acts as borrow-in)
//   a        in   4*DIGITS  BCD operand A, digit 0 in [3:0]
//   b        in   4*DIGITS  BCD operand B
//   cin      in   1         carry-in (add) / borrow-in (sub)
//   busy     out  1         high from the cycle after accepted start until done
//   done     out  1         one-cycle pulse: sum/cout/invalid valid from this cycle on
//   sum      out  4*DIGITS  BCD result, modulo 10^DIGITS
//   cout     out  1         add: decimal carry-out; sub: borrow-out (1 = A < B+cin)
//   invalid  out  1         1 = some digit of latched A or B exceeded 9
// BEHAVIOUR
//   Reset (async): state=IDLE; busy=0, done=0, sum=0, cout=0, invalid=0, digit index=0.
//   FSM IDLE -> CALC -> DONE -> IDLE.
//   IDLE: on start=1, latch a, b, mode, cin; check every nibble of a and b.
//     any nibble >9 -> invalid<=1, sum<=0, cout<=0, go DONE (no CALC).
//     else invalid<=0, carry<=(mode ? ~cin : cin), idx<=0, busy<=1, go CALC.
//   CALC: exactly DIGITS cycles; each cycle handles digit idx:
//     bd = mode ? (9 - b[idx]) : b[idx]   (nine's complement for subtract)
//     t  = a[idx] + bd + carry   (5-bit, max 19)
//     t>9 -> digit=t+6 (low 4 bits), carry=1; else digit=t, carry=0
//     write digit into sum[idx]; idx++; after digit DIGITS-1 go DONE.
//   Subtract: final carry=1 means no borrow. cout = mode ? ~carry : carry.
//     A negative result is left in ten's complement (e.g. -377 -> 9623 for DIGITS=4).
//   DONE: done=1 for one cycle, busy=0, return IDLE.
//     sum/cout/invalid hold until the next accepted start.
//   Latency: start sampled at edge 0 -> done high after edge DIGITS+1 (invalid path: after edge 1).
//   start while busy or in DONE: ignored, not queued; latched operands stay frozen.
//   start held high continuously: a new op is accepted on each return to IDLE (back-to-back).
//   Input changes during CALC have no effect.
//   rst mid-operation: abort immediately, all outputs return to reset values.
//   sum is written digit by digit during CALC and is not valid until done.
// TESTING (DIGITS=4)
//   1. add a=1234 b=8766 cin=0 -> sum=0000 cout=1 invalid=0; done exactly 5 cycles after start.
//   2. add a=9999 b=0000 cin=1 -> sum=0000 cout=1; add a=0045 b=0037 cin=0 -> sum=0082 cout=0.
//   3. sub a=0500 b=0123 cin=0 -> sum=0377 cout=0; sub a=0123 b=0500 -> sum=9623 cout=1;
//      sub a=0000 b=0000 cin=1 -> sum=9999 cout=1.
//   4. a=12A4 (nibble 0xA) b=0001 -> invalid=1, sum=0000, cout=0, done 1 cycle after start,
//      busy never high.
//   5. start pulsed again while busy with different operands -> ignored, first result unchanged;
//      start held high -> back-to-back ops, one done per operation.
//   6. rst asserted in CALC cycle 2 -> busy/done/sum/cout/invalid = 0 asynchronously;
//      next start completes correctly.

Source files
------------

// File: rtl/bcd_addsub_seq.sv
// ---------------------------------------------------------------------------
// bcd_addsub_seq
//   Multi-digit BCD adder/subtractor. Handles one decimal digit per clock,
//   least significant digit first. Subtraction adds the nine's complement of
//   B with an inverted borrow-in. A negative difference is therefore left in
//   ten's complement form, and cout reports the borrow.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active-high
//   start    in   operation request, sampled only in IDLE
//   mode     in   0 = A+B+cin, 1 = A-B-cin
//   a, b     in   BCD operands, digit 0 in [3:0]
//   cin      in   carry-in (add) / borrow-in (sub)
//   busy     out  high while digits are being computed
//   done     out  one-cycle pulse; sum/cout/invalid valid from this cycle on
//   sum      out  BCD result modulo 10^DIGITS
//   cout     out  add: decimal carry-out, sub: borrow-out
//   invalid  out  some latched operand digit exceeded 9
// ---------------------------------------------------------------------------
module bcd_addsub_seq #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                invalid
);
    localparam int W    = 4 * DIGITS;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic              r_mode;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;
    logic              r_busy;
    logic              r_done;
    logic [W-1:0]      r_sum;
    logic              r_cout;
    logic              r_invalid;

    logic              w_any_bad;
    logic              w_last;
    logic [3:0]        w_ad;
    logic [3:0]        w_bd_raw;
    logic [3:0]        w_bd;
    logic [4:0]        w_t;
    logic              w_gt9;
    logic [3:0]        w_dig;

    // Operand digit check on the live inputs, used at the accepting edge.
    always_comb begin
        w_any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9)
                w_any_bad = 1'b1;
        end
    end

    // Current digit pair selected by the digit index.
    always_comb begin
        w_ad     = 4'd0;
        w_bd_raw = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_ad     = r_a[4*i +: 4];
                w_bd_raw = r_b[4*i +: 4];
            end
        end
    end

    assign w_bd   = r_mode ? (4'd9 - w_bd_raw) : w_bd_raw;
    assign w_t    = {1'b0, w_ad} + {1'b0, w_bd} + {4'd0, r_carry};
    assign w_gt9  = (w_t > 5'd9);
    // +6 skips the six unused codes; the carry out of bit 3 is w_gt9 itself.
    assign w_dig  = w_gt9 ? (w_t[3:0] + 4'd6) : w_t[3:0];
    assign w_last = (r_idx == IDXW'(DIGITS - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_any_bad ? S_DONE : S_CALC;
            S_CALC:  if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath. done is registered out of DONE, so it is high during the first
    // IDLE cycle; a start held high is accepted in that same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_mode    <= 1'b0;
            r_carry   <= 1'b0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_mode <= mode;
                        r_idx  <= '0;
                        if (w_any_bad) begin
                            r_invalid <= 1'b1;
                            r_sum     <= '0;
                            r_cout    <= 1'b0;
                        end else begin
                            r_invalid <= 1'b0;
                            // Subtract: borrow-in becomes an inverted carry-in.
                            r_carry   <= mode ? ~cin : cin;
                            r_busy    <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_idx == IDXW'(i))
                            r_sum[4*i +: 4] <= w_dig;
                    end
                    r_carry <= w_gt9;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_busy <= 1'b0;
                        // Subtract: final carry of 1 means no borrow.
                        r_cout <= r_mode ? ~w_gt9 : w_gt9;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign sum     = r_sum;
    assign cout    = r_cout;
    assign invalid = r_invalid;

endmodule
